// File: rtl/product_accumulator_pkg.sv
// Shared types and helpers for product_accumulator: FSM state encoding and
// the frame-length normalisation (a length of 0 means a single-beat frame).
package product_accumulator_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    // Callers zero-extend into 32 bits and truncate the result back.
    function automatic logic [31:0] eff_frame_len(input logic [31:0] len);
        return (len == 32'd0) ? 32'd1 : len;
    endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// Product-stream input and frame-result output of product_accumulator.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; a producer holds valid and data stable until that edge.
interface product_accumulator_if #(
    parameter int DATA_WIDTH      = 4,
    parameter int ACC_WIDTH       = 8,
    parameter int FRAME_LEN_WIDTH = 4
);
    logic [DATA_WIDTH-1:0]      data_i;
    logic                       valid_i;
    logic                       ready_o;
    logic [FRAME_LEN_WIDTH-1:0] frame_len_i;
    logic                       clear_i;
    logic [ACC_WIDTH-1:0]       data_o;
    logic                       valid_o;
    logic                       ready_i;
    logic                       overflow_o;

    modport master (
        output data_i, valid_i, frame_len_i, clear_i, ready_i,
        input  ready_o, data_o, valid_o, overflow_o
    );

    modport slave (
        input  data_i, valid_i, frame_len_i, clear_i, ready_i,
        output ready_o, data_o, valid_o, overflow_o
    );
endinterface

// File: rtl/product_accumulator_beat_counter.sv
// beat_counter: loadable down-counter of beats still owed in the current
// frame; last flags that the next accepted beat completes the frame.
module beat_counter #(
    parameter int FRAME_LEN_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       load,
    input  logic [FRAME_LEN_WIDTH-1:0] load_value,
    input  logic                       decrement,
    output logic                       last
);
    logic [FRAME_LEN_WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (decrement) begin
            count <= count - FRAME_LEN_WIDTH'(1);
        end
    end

    assign last = (count == FRAME_LEN_WIDTH'(1));
endmodule

// File: rtl/product_accumulator.sv
// Frame accumulator for a product stream with a one-entry result register.
// Define PRODUCT_ACCUMULATOR_SATURATE_EN to clamp on overflow instead of wrapping.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int DATA_WIDTH      = 4,
    parameter int ACC_WIDTH       = 8,
    parameter int FRAME_LEN_WIDTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    product_accumulator_if.slave    bus,
    output state_t                  state_o
);
    if (ACC_WIDTH < DATA_WIDTH) begin : g_bad_width
        $error("product_accumulator: ACC_WIDTH must be >= DATA_WIDTH");
    end

    state_t state, state_next;

    logic [ACC_WIDTH-1:0]       acc, acc_add, result;
    logic [ACC_WIDTH:0]         sum;
    logic                       carry, sticky;
    logic                       res_valid, res_ovf;
    logic [FRAME_LEN_WIDTH-1:0] n_eff;
    logic                       cnt_last, last_beat;
    logic                       beat_accept, frame_done;
    logic                       cnt_load, cnt_dec, cnt_clear;
    logic                       ready;

    assign n_eff = FRAME_LEN_WIDTH'(eff_frame_len(32'(bus.frame_len_i)));

    // In IDLE the incoming beat is the first one, so the frame length decides.
    assign last_beat = (state == ST_IDLE) ? (n_eff == FRAME_LEN_WIDTH'(1)) : cnt_last;

    // Only a completing beat has to wait for the result register to drain.
    assign ready       = ~rst_i & ~(last_beat & res_valid & ~bus.ready_i);
    assign beat_accept = bus.valid_i & ready & ~bus.clear_i;

    assign sum   = {1'b0, acc} + {{(ACC_WIDTH + 1 - DATA_WIDTH){1'b0}}, bus.data_i};
    assign carry = sum[ACC_WIDTH];

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    assign acc_add = carry ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
    assign acc_add = sum[ACC_WIDTH-1:0];
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        frame_done = 1'b0;
        if (bus.clear_i) begin
            state_next = ST_IDLE;
        end else if (beat_accept) begin
            case (state)
                ST_IDLE: begin
                    if (n_eff == FRAME_LEN_WIDTH'(1)) begin
                        frame_done = 1'b1;
                    end else begin
                        cnt_load   = 1'b1;
                        state_next = ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (cnt_last) begin
                        frame_done = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign cnt_clear = bus.clear_i | frame_done;

    beat_counter #(
        .FRAME_LEN_WIDTH(FRAME_LEN_WIDTH)
    ) u_beat_counter (
        .clk        (clk_i),
        .rst        (rst_i),
        .clear      (cnt_clear),
        .load       (cnt_load),
        .load_value (n_eff - FRAME_LEN_WIDTH'(1)),
        .decrement  (cnt_dec),
        .last       (cnt_last)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc       <= '0;
            sticky    <= 1'b0;
            result    <= '0;
            res_valid <= 1'b0;
            res_ovf   <= 1'b0;
        end else begin
            if (bus.clear_i || frame_done) begin
                acc    <= '0;
                sticky <= 1'b0;
            end else if (beat_accept) begin
                acc    <= acc_add;
                sticky <= sticky | carry;
            end
            // A completing frame reloads the register even while it is drained.
            if (frame_done) begin
                result    <= acc_add;
                res_ovf   <= sticky | carry;
                res_valid <= 1'b1;
            end else if (res_valid && bus.ready_i) begin
                res_valid <= 1'b0;
            end
        end
    end

    assign bus.ready_o    = ready;
    assign bus.data_o     = result;
    assign bus.valid_o    = res_valid;
    assign bus.overflow_o = res_ovf;
    assign state_o        = state;
endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator (DATA=4, ACC=6, FRAME_LEN=3):
// table-driven frames plus hand sequences for backpressure, clear and reset.
module tb_product_accumulator;
    import product_accumulator_pkg::*;

    localparam int DW = 4;
    localparam int AW = 6;
    localparam int FW = 3;

    logic   clk;
    logic   rst_i;
    state_t state;

    product_accumulator_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .FRAME_LEN_WIDTH(FW)) bus();

    product_accumulator #(
        .DATA_WIDTH      (DW),
        .ACC_WIDTH       (AW),
        .FRAME_LEN_WIDTH (FW)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .bus     (bus),
        .state_o (state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int tests_run    = 0;
    int tests_failed = 0;
    logic [AW:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // A result transfers on the edge after this negedge sample.
    always @(negedge clk) begin
        if (!rst_i && bus.valid_o && bus.ready_i) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL spurious_result: got data %0d with no result expected", bus.data_o);
            end else begin
                logic [AW:0] e;
                e = exp_q.pop_front();
                check("result_data", 32'(bus.data_o), 32'(e[AW-1:0]));
                check("result_ovf", 32'(bus.overflow_o), 32'(e[AW]));
            end
        end
    end

    // ---------------- driver ----------------
    // Called between a rising edge and the following falling edge.
    task automatic send_beat(input logic [DW-1:0] d, input logic [FW-1:0] n,
                             input bit last, input logic [AW:0] exp);
        int  waited;
        bit  accepted;
        waited = 0;
        bus.data_i      = d;
        bus.frame_len_i = n;
        bus.valid_i     = 1'b1;
        @(negedge clk);
        while (!bus.ready_o && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        accepted = bus.ready_o;
        if (!accepted) begin
            tests_run++;
            tests_failed++;
            $display("FAIL beat_timeout: ready_o %0d after %0d cycles, required 1", bus.ready_o, waited);
        end
        @(posedge clk);
        #1;
        if (accepted && last) exp_q.push_back(exp);
    endtask

    task automatic idle_cycles(input int n);
        bus.valid_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [FW-1:0] n;
        logic [3:0]    cnt;
        logic [31:0]   beats;   // beat j lives in nibble j
        logic [AW-1:0] exp_d;
        logic          exp_o;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs[NVEC];

    initial begin
        vecs[0] = '{3'd4, 4'd4, 32'h0000_9753, 6'd24, 1'b0};
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
        vecs[1] = '{3'd5, 4'd5, 32'h000F_FFFF, 6'd63, 1'b1};
        vecs[7] = '{3'd6, 4'd6, 32'h00BB_BBBB, 6'd63, 1'b1};
`else
        vecs[1] = '{3'd5, 4'd5, 32'h000F_FFFF, 6'd11, 1'b1};
        vecs[7] = '{3'd6, 4'd6, 32'h00BB_BBBB, 6'd2,  1'b1};
`endif
        vecs[2] = '{3'd0, 4'd1, 32'h0000_0007, 6'd7,  1'b0};
        vecs[3] = '{3'd1, 4'd1, 32'h0000_0000, 6'd0,  1'b0};
        vecs[4] = '{3'd7, 4'd7, 32'h0999_9999, 6'd63, 1'b0};
        vecs[5] = '{3'd2, 4'd2, 32'h0000_00FF, 6'd30, 1'b0};
        vecs[6] = '{3'd3, 4'd3, 32'h0000_0FFF, 6'd45, 1'b0};
        vecs[8] = '{3'd1, 4'd1, 32'h0000_000F, 6'd15, 1'b0};

        rst_i           = 1'b1;
        bus.valid_i     = 1'b0;
        bus.data_i      = '0;
        bus.frame_len_i = '0;
        bus.clear_i     = 1'b0;
        bus.ready_i     = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready_low", 32'(bus.ready_o), 0);
        check("rst_valid_low", 32'(bus.valid_o), 0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("post_rst_data", 32'(bus.data_o), 0);
        check("post_rst_valid", 32'(bus.valid_o), 0);
        check("post_rst_ovf", 32'(bus.overflow_o), 0);
        check("post_rst_ready", 32'(bus.ready_o), 1);
        check("post_rst_state", 32'(state), 32'(ST_IDLE));
        @(posedge clk);
        #1;

        // Basic frame with latency and single-cycle valid
        send_beat(4'd3, 3'd4, 1'b0, '0);
        send_beat(4'd5, 3'd4, 1'b0, '0);
        send_beat(4'd7, 3'd4, 1'b0, '0);
        send_beat(4'd9, 3'd4, 1'b1, {1'b0, 6'd24});
        bus.valid_i = 1'b0;
        check("lat_valid", 32'(bus.valid_o), 1);
        check("lat_data", 32'(bus.data_o), 24);
        @(posedge clk);
        #1;
        check("lat_valid_one_cycle", 32'(bus.valid_o), 0);
        idle_cycles(2);

        // Table: back-to-back frames with ready_i held high
        for (int i = 0; i < NVEC; i++) begin
            for (int j = 0; j < int'(vecs[i].cnt); j++) begin
                send_beat(vecs[i].beats[j*4 +: 4], vecs[i].n,
                          (j == int'(vecs[i].cnt) - 1), {vecs[i].exp_o, vecs[i].exp_d});
            end
        end
        idle_cycles(3);

        // Backpressure: N=1, results 2,4,6 with the consumer stalled
        bus.ready_i = 1'b0;
        send_beat(4'd2, 3'd1, 1'b1, {1'b0, 6'd2});
        bus.data_i = 4'd4;
        check("bp_held_valid", 32'(bus.valid_o), 1);
        check("bp_held_data", 32'(bus.data_o), 2);
        @(negedge clk);
        check("bp_ready_low", 32'(bus.ready_o), 0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check("bp_data_stable", 32'(bus.data_o), 2);
        end
        bus.ready_i = 1'b1;
        send_beat(4'd4, 3'd1, 1'b1, {1'b0, 6'd4});
        send_beat(4'd6, 3'd1, 1'b1, {1'b0, 6'd6});
        idle_cycles(3);

        // Clear aborts the partial frame and discards the concurrent beat
        send_beat(4'd1, 3'd4, 1'b0, '0);
        send_beat(4'd2, 3'd4, 1'b0, '0);
        bus.clear_i = 1'b1;
        bus.data_i  = 4'd3;
        bus.valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.clear_i = 1'b0;
        check("clear_state", 32'(state), 32'(ST_IDLE));
        for (int k = 0; k < 4; k++) send_beat(4'd1, 3'd4, (k == 3), {1'b0, 6'd4});
        idle_cycles(3);

        // Frame length change mid-frame is ignored
        send_beat(4'd1, 3'd4, 1'b0, '0);
        send_beat(4'd2, 3'd2, 1'b0, '0);
        check("fl_change_state", 32'(state), 32'(ST_ACCUM));
        send_beat(4'd3, 3'd2, 1'b0, '0);
        send_beat(4'd4, 3'd2, 1'b1, {1'b0, 6'd10});
        idle_cycles(3);

        // Reset mid-frame with a held result
        bus.ready_i = 1'b0;
        send_beat(4'd5, 3'd1, 1'b0, '0);
        send_beat(4'd1, 3'd4, 1'b0, '0);
        send_beat(4'd1, 3'd4, 1'b0, '0);
        bus.valid_i = 1'b0;
        rst_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_valid", 32'(bus.valid_o), 0);
        check("midrst_ready", 32'(bus.ready_o), 0);
        @(posedge clk);
        #1;
        rst_i       = 1'b0;
        bus.ready_i = 1'b1;
        for (int k = 0; k < 4; k++) send_beat(4'd1, 3'd4, (k == 3), {1'b0, 6'd4});
        idle_cycles(5);

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
